// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode
// constants and a latency helper for anyone scheduling around a transfer.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    TRANSFER = 3'd2,
    HOLD     = 3'd3,
    DONE     = 3'd4
  } spi_state_t;

  // Modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Cycles from the accepted start edge to the complete pulse
  function automatic int unsigned spi_latency(input int unsigned data_width,
                                              input int unsigned clk_div,
                                              input int unsigned cs_setup,
                                              input int unsigned cs_hold);
    return 1 + (cs_setup + 2 * data_width + cs_hold) * clk_div;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider tick generator: one-cycle tick every CLK_DIV cycles of i_clock,
// restarting a full period whenever clear is asserted.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || clear) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised single-clock SPI master: all four modes, programmable SCLK
// divider, CS setup/hold in SCLK half-periods, and NUM_CS chip selects.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 50,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int NUM_CS     = 1,
  localparam int CS_SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CS_SEL_W-1:0]   cs_sel,
  input  logic                  start_transfer,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  o_transaction_complete,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_CS-1:0]     CS,
  output logic                  SCLK
);

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_TK  = (2 * DATA_WIDTH > MAX_SH) ? 2 * DATA_WIDTH : MAX_SH;
  localparam int CNT_W   = $clog2(MAX_TK + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(2 * DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  spi_state_t            state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic                  start_p1;
  logic                  start_edge;
  logic                  cpha_q, cpha_nxt;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_nxt;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic [NUM_CS-1:0]     cs_nxt;
  logic                  sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic                  div_clear, div_tick;
  logic                  leading, final_edge, sample_en, shift_en;

  // Active-low one-hot select; an out-of-range index asserts nothing
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_SEL_W'(i)) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .clear   (div_clear),
    .tick    (div_tick)
  );

  assign start_edge = start_transfer & ~start_p1;
  assign div_clear  = (state_q == IDLE) || (state_q == DONE);

  // Tick k of TRANSFER (k = cnt_q + 1) is a leading edge when k is odd
  assign leading    = ~cnt_q[0];
  assign final_edge = (cnt_q == XFER_LAST);
  assign sample_en  = leading ^ cpha_q;
  assign shift_en   = cpha_q ? leading : (~leading & ~final_edge);

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    cpha_nxt    = cpha_q;
    tx_sr_nxt   = tx_sr_q;
    rx_sr_nxt   = rx_sr_q;
    rx_data_nxt = rx_data;
    cs_nxt      = CS;
    sclk_nxt    = SCLK;
    mosi_nxt    = MOSI;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_nxt = cpol;
        mosi_nxt = 1'b0;
        if (start_edge && enable) begin
          state_nxt = SETUP;
          cnt_nxt   = '0;
          cpha_nxt  = cpha;
          cs_nxt    = cs_decode(cs_sel);
          busy_nxt  = 1'b1;
          // cpha=0 must present the MSB before the first (sampling) edge
          if (cpha) begin
            tx_sr_nxt = tx_data;
          end else begin
            tx_sr_nxt = {tx_data[DATA_WIDTH-2:0], 1'b0};
            mosi_nxt  = tx_data[DATA_WIDTH-1];
          end
        end
      end

      SETUP: begin
        if (div_tick) begin
          if (cnt_q == SETUP_LAST) begin
            state_nxt = TRANSFER;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end

      TRANSFER: begin
        if (div_tick) begin
          sclk_nxt = ~SCLK;
          if (sample_en) begin
            rx_sr_nxt = {rx_sr_q[DATA_WIDTH-2:0], MISO};
          end
          if (shift_en) begin
            mosi_nxt  = tx_sr_q[DATA_WIDTH-1];
            tx_sr_nxt = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (final_edge) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            mosi_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (div_tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_nxt   = DONE;
            cnt_nxt     = '0;
            cs_nxt      = '1;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            rx_data_nxt = rx_sr_q;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered control and outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      start_p1               <= 1'b0;
      cpha_q                 <= 1'b0;
      busy                   <= 1'b0;
      o_transaction_complete <= 1'b0;
      rx_data                <= '0;
      MOSI                   <= 1'b0;
      CS                     <= '1;
      SCLK                   <= 1'b0;
    end else begin
      state_q                <= state_nxt;
      cnt_q                  <= cnt_nxt;
      start_p1               <= start_transfer;
      cpha_q                 <= cpha_nxt;
      busy                   <= busy_nxt;
      o_transaction_complete <= done_nxt;
      rx_data                <= rx_data_nxt;
      MOSI                   <= mosi_nxt;
      CS                     <= cs_nxt;
      SCLK                   <= sclk_nxt;
    end
  end

  // Shift registers carry data only
  always_ff @(posedge i_clock) begin
    tx_sr_q <= tx_sr_nxt;
    rx_sr_q <= rx_sr_nxt;
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: table of transfers across all modes
// against a slave model, plus reset, enable and back-to-back sequences.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int EXP_DONE = 145;

  logic        i_clock = 1'b0;
  logic        i_reset, enable, cpol, cpha, start_transfer;
  logic [1:0]  cs_sel;
  logic [15:0] tx_data, rx_data;
  logic        busy, o_transaction_complete, MOSI, MISO, SCLK;
  logic [3:0]  CS;

  int checks = 0;
  int errors = 0;

  spi_master_param #(
    .DATA_WIDTH (16),
    .CLK_DIV    (4),
    .CS_SETUP   (2),
    .CS_HOLD    (2),
    .NUM_CS     (4)
  ) dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .enable                 (enable),
    .cpol                   (cpol),
    .cpha                   (cpha),
    .cs_sel                 (cs_sel),
    .start_transfer         (start_transfer),
    .tx_data                (tx_data),
    .busy                   (busy),
    .o_transaction_complete (o_transaction_complete),
    .rx_data                (rx_data),
    .MOSI                   (MOSI),
    .MISO                   (MISO),
    .CS                     (CS),
    .SCLK                   (SCLK)
  );

  always #5 i_clock = ~i_clock;

  // Slave model: reacts to SCLK edges seen one negedge later, using the MOSI
  // level from before the edge, as a real slave would.
  logic        loopback = 1'b0;
  logic        s_cpol = 1'b0, s_cpha = 1'b0;
  logic [15:0] slave_word = '0, slave_rx = '0, s_tx = '0;
  logic        s_miso = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;

  assign MISO = loopback ? MOSI : s_miso;

  always @(negedge i_clock) begin
    if (CS == 4'hF) begin
      s_tx   <= s_cpha ? slave_word : (slave_word << 1);
      s_miso <= s_cpha ? 1'b0 : slave_word[15];
    end else if (SCLK != prev_sclk) begin
      if ((SCLK != s_cpol) ^ s_cpha) begin
        slave_rx <= {slave_rx[14:0], prev_mosi};
      end else begin
        s_miso <= s_tx[15];
        s_tx   <= s_tx << 1;
      end
    end
    prev_sclk <= SCLK;
    prev_mosi <= MOSI;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transfer, with a spurious start edge and input scrambling mid-way
  task automatic run_xfer(input logic [1:0] mode, input logic [15:0] tx,
                          input logic [15:0] sw, input logic lb,
                          input logic [1:0] sel, input logic drop_en,
                          input logic [3:0] exp_cs,
                          output int done_k, output int toggles,
                          output int rises, output int cs_bad, output int n_done,
                          output logic idle_sclk, output logic [3:0] idle_cs);
    logic prev;
    cpol = mode[1]; cpha = mode[0]; s_cpol = mode[1]; s_cpha = mode[0];
    cs_sel = sel; tx_data = tx; slave_word = sw; loopback = lb;
    repeat (3) @(negedge i_clock);
    idle_sclk = SCLK;
    idle_cs   = CS;
    start_transfer = 1'b1;
    done_k = -1; toggles = 0; rises = 0; cs_bad = 0; n_done = 0;
    prev = SCLK;
    for (int k = 1; k <= EXP_DONE + 20; k++) begin
      @(negedge i_clock);
      if (SCLK != prev && done_k < 0) begin
        toggles++;
        if (SCLK) rises++;
      end
      prev = SCLK;
      if (o_transaction_complete) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k < 0) begin
        if (!busy || CS != exp_cs) cs_bad++;
      end else if (busy || CS != 4'hF) begin
        cs_bad++;
      end
      if (k == 3)  start_transfer = 1'b0;
      if (k == 20 && drop_en) enable = 1'b0;
      if (k == 40) start_transfer = 1'b1;
      if (k == 42) start_transfer = 1'b0;
      if (k == 50) begin
        tx_data = ~tx; cpol = ~mode[1]; cpha = ~mode[0]; cs_sel = sel + 2'd1;
      end
    end
    enable = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] tx;
    logic [15:0] sw;
    logic        lb;
    logic [1:0]  sel;
    logic        drop_en;
    logic [15:0] exp_rx;
    logic [15:0] exp_slave;
    logic [3:0]  exp_cs;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int dk, tg, rs, cb, nd, bad, k_done;
    logic isc;
    logic [3:0] ics;

    vecs[0] = '{SPI_MODE0, 16'hA5C3, 16'h0000, 1'b1, 2'd0, 1'b0, 16'hA5C3, 16'hA5C3, 4'b1110};
    vecs[1] = '{SPI_MODE3, 16'h8001, 16'h1234, 1'b0, 2'd0, 1'b0, 16'h1234, 16'h8001, 4'b1110};
    vecs[2] = '{SPI_MODE1, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 1'b0, 16'h0000, 16'hFFFF, 4'b1101};
    vecs[3] = '{SPI_MODE1, 16'h0000, 16'hFFFF, 1'b0, 2'd0, 1'b0, 16'hFFFF, 16'h0000, 4'b1110};
    vecs[4] = '{SPI_MODE2, 16'hFFFF, 16'h0000, 1'b0, 2'd3, 1'b0, 16'h0000, 16'hFFFF, 4'b0111};
    vecs[5] = '{SPI_MODE2, 16'h0000, 16'hFFFF, 1'b0, 2'd2, 1'b0, 16'hFFFF, 16'h0000, 4'b1011};
    vecs[6] = '{SPI_MODE0, 16'h3C5A, 16'h9ABC, 1'b0, 2'd2, 1'b1, 16'h9ABC, 16'h3C5A, 4'b1011};
    vecs[7] = '{SPI_MODE1, 16'h1E69, 16'h8421, 1'b0, 2'd0, 1'b0, 16'h8421, 16'h1E69, 4'b1110};
    vecs[8] = '{SPI_MODE2, 16'h7001, 16'hF00E, 1'b0, 2'd1, 1'b0, 16'hF00E, 16'h7001, 4'b1101};

    i_reset = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; cs_sel = '0;
    start_transfer = 1'b0; tx_data = '0;
    repeat (3) @(negedge i_clock);
    check("reset_busy", busy, 0);
    check("reset_done", o_transaction_complete, 0);
    check("reset_rx", rx_data, 0);
    check("reset_mosi", MOSI, 0);
    check("reset_cs", CS, 4'hF);
    check("reset_sclk", SCLK, 0);
    i_reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].mode, vecs[i].tx, vecs[i].sw, vecs[i].lb, vecs[i].sel,
               vecs[i].drop_en, vecs[i].exp_cs, dk, tg, rs, cb, nd, isc, ics);
      check($sformatf("v%0d_idle_sclk", i), isc, vecs[i].mode[1]);
      check($sformatf("v%0d_idle_cs", i), ics, 4'hF);
      check($sformatf("v%0d_done_cycle", i), dk, EXP_DONE);
      check($sformatf("v%0d_toggles", i), tg, 32);
      check($sformatf("v%0d_rises", i), rs, 16);
      check($sformatf("v%0d_cs_busy", i), cb, 0);
      check($sformatf("v%0d_n_done", i), nd, 1);
      check($sformatf("v%0d_rx", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_slave_rx", i), slave_rx, vecs[i].exp_slave);
    end

    // Start edge with enable low is dropped, not queued
    enable = 1'b0; bad = 0;
    @(negedge i_clock); start_transfer = 1'b1;
    repeat (3) @(negedge i_clock);
    start_transfer = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clock);
      if (busy || CS != 4'hF || o_transaction_complete) bad++;
    end
    enable = 1'b1;
    repeat (5) @(negedge i_clock);
    check("en_low_bad_cycles", bad, 0);
    check("en_low_not_queued", busy, 0);

    // Reset during a transfer
    cpol = 1'b1; cpha = 1'b1; s_cpol = 1'b1; s_cpha = 1'b1; cs_sel = 2'd1;
    tx_data = 16'h5555; slave_word = 16'hAAAA; loopback = 1'b0;
    repeat (3) @(negedge i_clock);
    start_transfer = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge i_clock);
      if (k == 3) start_transfer = 1'b0;
    end
    check("rst_mid_busy_before", busy, 1);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("rst_mid_cs", CS, 4'hF);
    check("rst_mid_sclk", SCLK, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rx", rx_data, 0);
    check("rst_mid_done", o_transaction_complete, 0);
    i_reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clock);
      if (o_transaction_complete) nd++;
    end
    check("rst_mid_no_pulse", nd, 0);

    run_xfer(SPI_MODE0, 16'h0F0F, 16'h0000, 1'b1, 2'd0, 1'b0, 4'b1110,
             dk, tg, rs, cb, nd, isc, ics);
    check("post_rst_done_cycle", dk, EXP_DONE);
    check("post_rst_toggles", tg, 32);
    check("post_rst_rx", rx_data, 16'h0F0F);

    // Edge in the cycle after DONE is accepted
    cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; cs_sel = 2'd0;
    tx_data = 16'h1111; loopback = 1'b1;
    repeat (3) @(negedge i_clock);
    start_transfer = 1'b1;
    k_done = -1;
    for (int k = 1; k <= EXP_DONE + 20; k++) begin
      @(negedge i_clock);
      if (k == 3) start_transfer = 1'b0;
      if (o_transaction_complete) begin
        k_done = k;
        break;
      end
    end
    check("b2b_first_done", k_done, EXP_DONE);
    check("b2b_first_rx", rx_data, 16'h1111);
    @(negedge i_clock);
    tx_data = 16'h2222; start_transfer = 1'b1;
    @(negedge i_clock);
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_cs", CS, 4'b1110);
    k_done = -1;
    for (int k = 2; k <= EXP_DONE + 20; k++) begin
      @(negedge i_clock);
      if (k == 4) start_transfer = 1'b0;
      if (o_transaction_complete) begin
        k_done = k;
        break;
      end
    end
    check("b2b_second_done", k_done, EXP_DONE);
    check("b2b_second_rx", rx_data, 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised, single-clock SPI master for the HDP-1280-2 and future peripherals (DACs, flash, sensors).
- Supports all four SPI modes (CPOL/CPHA), configurable transfer width, programmable SCLK divider, configurable CS setup/hold and multiple chip selects.
- All logic runs in the i_clock domain using divider tick enables; no derived clocks.
- Sits between the board-control FSM and external SPI slaves; the control FSM issues transfers and reads back results.

Parameters:
- DATA_WIDTH, 16, bits per transfer, MSB first; legal range >= 2.
- CLK_DIV, 50, i_clock cycles per SCLK half-period; legal range >= 2.
- CS_SETUP, 2, SCLK half-periods with CS low before the first SCLK edge; legal range >= 1.
- CS_HOLD, 2, SCLK half-periods with CS low after the last SCLK edge; legal range >= 1.
- NUM_CS, 1, number of chip-select lines; legal range >= 1.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- enable  in  1  start edges are accepted only while enable is high.
- cpol  in  1  SCLK idle level; latched at start.
- cpha  in  1  0 = sample on the leading edge, 1 = sample on the trailing edge; latched at start.
- cs_sel  in  max(1,$clog2(NUM_CS))  selects which CS line to drive; latched at start.
- start_transfer  in  1  a rising edge requests a transfer.
- tx_data  in  DATA_WIDTH  word to transmit; latched at start.
- busy  out  1  high while a transfer is in progress.
- o_transaction_complete  out  1  one-cycle pulse when a transfer finishes.
- rx_data  out  DATA_WIDTH  last received word.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS  out  NUM_CS  active-low chip selects.
- SCLK  out  1  serial clock.

Behaviour:
- Reset values: busy=0, o_transaction_complete=0, rx_data=0, MOSI=0, CS=all 1, SCLK=0, state=IDLE. All outputs are registered.
- Edge detection: start_transfer is registered and start_edge = start_transfer & ~prev.
  - An edge is accepted only when state==IDLE and enable==1. Otherwise it is dropped, not queued.
- On acceptance (cycle 0 = the edge cycle):
  - Latch tx_data, cpol, cpha and cs_sel.
  - Clear the divider counter.
  - Go to SETUP. At cycle 1: CS[cs_sel]=0, busy=1.
- Divider: counter runs CLK_DIV-1 down to 0 and emits tick at 0. It is held cleared in IDLE.
- SETUP: lasts CS_SETUP ticks. SCLK stays at cpol.
  - If cpha=0, MOSI presents the MSB during SETUP.
- TRANSFER: lasts 2*DATA_WIDTH ticks. Each tick toggles SCLK; odd ticks are leading edges, even ticks are trailing edges.
  - cpha=0: sample MISO on leading edges; shift MOSI on trailing edges (except the final one).
  - cpha=1: shift MOSI (first bit = MSB) on leading edges; sample MISO on trailing edges.
  - Exactly DATA_WIDTH samples are taken. The rx shift register ends holding all bits, with the first-sampled bit at the MSB.
- HOLD: lasts CS_HOLD ticks. SCLK is at cpol, CS stays low, MOSI=0.
- DONE: lasts one i_clock cycle. In that cycle:
  - CS returns to all 1.
  - rx_data is loaded from the rx shift register.
  - o_transaction_complete=1 and busy=0.
  - Next state is IDLE.
  - This is cycle N = 1 + (CS_SETUP + 2*DATA_WIDTH + CS_HOLD)*CLK_DIV after the edge.
- New start: an edge arriving in the cycle after DONE is accepted.
- IDLE: SCLK follows the registered cpol input (one-cycle lag). MOSI=0. rx_data holds its value.
- enable deasserted mid-transfer: the current transfer completes normally; only new starts are blocked.
- Input changes mid-transfer: tx_data, cpol, cpha and cs_sel have no effect until the next start.
- i_reset mid-transfer: the next cycle applies reset values. No complete pulse is emitted and rx_data is cleared.
- Exactly one CS line is ever low; when cs_sel >= NUM_CS, no CS is asserted but the transfer still runs.

Decomposition:
- Package spi_pkg:
  - State encoding: IDLE, SETUP, TRANSFER, HOLD, DONE.
  - Mode constants: SPI_MODE0..3 as {cpol, cpha}.
  - Function computing the total transfer latency, for benches.
- Sub-module spi_clk_gen:
  - Parameter CLK_DIV.
  - Ports i_clock, i_reset, clear, tick.
  - Reused by future serial blocks.

Test Plan:
- Mode 0 (DATA_WIDTH=16, CLK_DIV=4, CS_SETUP=2, CS_HOLD=2), MISO looped to MOSI, tx_data=16'hA5C3, start edge at cycle 0:
  - CS[0] falls at cycle 1.
  - 16 SCLK rising edges occur.
  - o_transaction_complete pulses at cycle 145.
  - rx_data=16'hA5C3.
- Mode 3, slave model returns 16'h1234 and samples MOSI on rising edges, tx_data=16'h8001:
  - SCLK idles high.
  - Slave captures 16'h8001.
  - rx_data=16'h1234.
- Mode 1 and mode 2, tx_data=16'hFFFF then 16'h0000 with a slave model:
  - The correct edge sampling is checked.
  - No extra or missing SCLK edges: exactly 32 toggles each.
- NUM_CS=4, cs_sel=2:
  - CS=4'b1011 during the transfer and 4'b1111 otherwise.
  - A second start edge mid-transfer is ignored: exactly one complete pulse.
- enable=0 with a start edge: no state change and busy stays 0.
  - Dropping enable mid-transfer: the transfer still completes and rx_data is updated.
- i_reset at cycle 60 of a transfer:
  - CS=all 1, SCLK=0, busy=0 and rx_data=0 on the next cycle.
  - No complete pulse.
  - A following start produces a normal transfer.
